// File: rtl/cpu6502_pkg.sv
// Shared encodings for the cpu6502 sequencing logic: interrupt sources,
// vector low bytes and the injected BRK opcode.
package cpu6502_pkg;

  typedef enum logic [1:0] {
    INT_SRC_BRK   = 2'd0,
    INT_SRC_IRQ   = 2'd1,
    INT_SRC_NMI   = 2'd2,
    INT_SRC_RESET = 2'd3
  } int_src_t;

  localparam logic [7:0] VEC_LO_NMI   = 8'hFA;
  localparam logic [7:0] VEC_LO_RESET = 8'hFC;
  localparam logic [7:0] VEC_LO_IRQ   = 8'hFE;

  localparam logic [7:0] OPCODE_BRK = 8'h00;

  localparam int TCU_WIDTH_DEFAULT = 4;

  // Software BRK and IRQ share the same vector.
  function automatic logic [7:0] vector_lo(int_src_t src);
    case (src)
      INT_SRC_NMI:   return VEC_LO_NMI;
      INT_SRC_RESET: return VEC_LO_RESET;
      default:       return VEC_LO_IRQ;
    endcase
  endfunction

endpackage

// File: rtl/cpu6502_nmi_edge_detect.sv
// NMI input synchroniser followed by a falling-edge latch; a new edge beats
// a clear arriving in the same cycle so no request is ever lost.
module cpu6502_nmi_edge_detect
  import cpu6502_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic nmi_n,
  input  logic clear,
  output logic pending
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              fell;

  assign fell = prev_q & ~sync_q[STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q  <= '1;
      prev_q  <= 1'b1;
      pending <= 1'b0;
    end else begin
      sync_q  <= STAGES'({sync_q, nmi_n});
      prev_q  <= sync_q[STAGES-1];
      pending <= fell | (pending & ~clear);
    end
  end

endmodule

// File: rtl/cpu6502_timing_sequencer.sv
// T-state counter, instruction register and interrupt injection for the cpu6502 core.
// Define CPU6502_RDY_EN to enable RDY stalling of read cycles; otherwise i_rdy is unused.
module cpu6502_timing_sequencer
  import cpu6502_pkg::*;
#(
  parameter int TCU_WIDTH       = TCU_WIDTH_DEFAULT,
  parameter int NMI_SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [TCU_WIDTH-1:0] i_tcu_next,
  input  logic [7:0]           i_data,
  input  logic                 i_rw,
  input  logic                 i_rdy,
  input  logic                 i_nmi_n,
  input  logic                 i_irq_n,
  input  logic                 i_i_flag,
  output logic [TCU_WIDTH-1:0] o_tcu,
  output logic [7:0]           o_ir,
  output logic                 o_sync,
  output logic [1:0]           o_int_src,
  output logic [7:0]           o_vector_lo,
  output logic                 o_int_active,
  output logic                 o_pc_inc_inhibit,
  output logic                 o_write_inhibit,
  output logic                 o_nmi_pending,
  output logic                 o_jam
);

  localparam logic [TCU_WIDTH-1:0] TCU_JAM   = '1;
  localparam logic [TCU_WIDTH-1:0] TCU_RESET = TCU_WIDTH'(1);

  logic       stall;
  logic       boundary;
  logic       nmi_take;
  logic       irq_take;
  int_src_t   src_q;
  int_src_t   src_d;
  logic [7:0] ir_d;
  logic       active_d;

`ifdef CPU6502_RDY_EN
  assign stall = ~i_rdy & i_rw;
`else
  logic unused_rdy;
  assign unused_rdy = i_rdy;
  assign stall      = 1'b0;
`endif

  assign o_sync    = (o_tcu == '0);
  assign boundary  = o_sync & ~stall & ~o_jam;
  assign nmi_take  = boundary & o_nmi_pending;
  assign irq_take  = boundary & ~o_nmi_pending & ~i_irq_n & ~i_i_flag;
  assign o_int_src = src_q;

  cpu6502_nmi_edge_detect #(
    .STAGES (NMI_SYNC_STAGES)
  ) u_nmi_edge (
    .clk     (i_clk),
    .reset_n (i_reset_n),
    .nmi_n   (i_nmi_n),
    .clear   (nmi_take),
    .pending (o_nmi_pending)
  );

  // Source of a non-BRK opcode is left as-is; it only matters while int_active.
  always_comb begin
    src_d    = src_q;
    ir_d     = o_ir;
    active_d = o_int_active;
    if (boundary) begin
      active_d = nmi_take | irq_take;
      if (nmi_take) begin
        ir_d  = OPCODE_BRK;
        src_d = INT_SRC_NMI;
      end else if (irq_take) begin
        ir_d  = OPCODE_BRK;
        src_d = INT_SRC_IRQ;
      end else begin
        ir_d = i_data;
        if (i_data == OPCODE_BRK) src_d = INT_SRC_BRK;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_tcu            <= TCU_RESET;
      o_ir             <= OPCODE_BRK;
      src_q            <= INT_SRC_RESET;
      o_vector_lo      <= VEC_LO_RESET;
      o_int_active     <= 1'b1;
      o_pc_inc_inhibit <= 1'b1;
      o_write_inhibit  <= 1'b1;
      o_jam            <= 1'b0;
    end else begin
      if (!stall && !o_jam) begin
        o_tcu <= i_tcu_next;
        if (i_tcu_next == TCU_JAM) o_jam <= 1'b1;
      end
      o_ir             <= ir_d;
      src_q            <= src_d;
      o_vector_lo      <= vector_lo(src_d);
      o_int_active     <= active_d;
      o_pc_inc_inhibit <= active_d;
      o_write_inhibit  <= active_d && (src_d == INT_SRC_RESET);
    end
  end

endmodule

// File: tb/tb_cpu6502_timing_sequencer.sv
// Scoreboard bench for cpu6502_timing_sequencer: a rule-level model predicts every
// cycle's outputs, a negedge monitor compares them against the DUT.
module tb_cpu6502_timing_sequencer;

  localparam int S = 2;
`ifdef CPU6502_RDY_EN
  localparam bit RDY_EN = 1'b1;
`else
  localparam bit RDY_EN = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic [3:0] i_tcu_next;
  logic [7:0] i_data;
  logic       i_rw, i_rdy, i_nmi_n, i_irq_n, i_i_flag;
  logic [3:0] o_tcu;
  logic [7:0] o_ir, o_vector_lo;
  logic       o_sync;
  logic [1:0] o_int_src;
  logic       o_int_active, o_pc_inc_inhibit, o_write_inhibit, o_nmi_pending, o_jam;

  cpu6502_timing_sequencer #(
    .TCU_WIDTH       (4),
    .NMI_SYNC_STAGES (S)
  ) dut (
    .i_clk            (i_clk),
    .i_reset_n        (i_reset_n),
    .i_tcu_next       (i_tcu_next),
    .i_data           (i_data),
    .i_rw             (i_rw),
    .i_rdy            (i_rdy),
    .i_nmi_n          (i_nmi_n),
    .i_irq_n          (i_irq_n),
    .i_i_flag         (i_i_flag),
    .o_tcu            (o_tcu),
    .o_ir             (o_ir),
    .o_sync           (o_sync),
    .o_int_src        (o_int_src),
    .o_vector_lo      (o_vector_lo),
    .o_int_active     (o_int_active),
    .o_pc_inc_inhibit (o_pc_inc_inhibit),
    .o_write_inhibit  (o_write_inhibit),
    .o_nmi_pending    (o_nmi_pending),
    .o_jam            (o_jam)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [3:0] tcu;
    logic [7:0] ir;
    logic       sync;
    logic [1:0] src;
    logic [7:0] vec;
    logic       active;
    logic       pcinh;
    logic       wi;
    logic       pend;
    logic       jam;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state, in terms of the architectural rules.
  int m_tcu = 1, m_ir = 0, m_src = 3, m_len = 2;
  bit m_active = 1, m_pend = 0, m_jam = 0;
  bit hist [0:S+1];  // hist[k] = i_nmi_n sampled k edges ago

  function automatic obs_t expect_now();
    obs_t e;
    e.tcu    = 4'(m_tcu);
    e.ir     = 8'(m_ir);
    e.sync   = (m_tcu == 0);
    e.src    = 2'(m_src);
    e.vec    = (m_src == 2) ? 8'hFA : (m_src == 3) ? 8'hFC : 8'hFE;
    e.active = m_active;
    e.pcinh  = m_active;
    e.wi     = (m_src == 3) && m_active;
    e.pend   = m_pend;
    e.jam    = m_jam;
    return e;
  endfunction

  task automatic model_step();
    bit set_edge, stall, consume;
    if (!i_reset_n) begin
      m_tcu = 1; m_ir = 0; m_src = 3; m_active = 1; m_pend = 0; m_jam = 0;
      foreach (hist[k]) hist[k] = 1'b1;
    end else begin
      for (int k = S + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0]  = i_nmi_n;
      // A falling edge becomes visible NMI_SYNC_STAGES+1 edges after it is sampled.
      set_edge = !hist[S] && hist[S+1];
      stall    = RDY_EN && !i_rdy && i_rw;
      consume  = 1'b0;
      if (!m_jam && !stall) begin
        if (m_tcu == 0) begin
          if (m_pend) begin
            m_ir = 0; m_src = 2; m_active = 1; consume = 1'b1;
          end else if (!i_irq_n && !i_i_flag) begin
            m_ir = 0; m_src = 1; m_active = 1;
          end else begin
            m_ir = int'(i_data);
            if (i_data == 8'h00) m_src = 0;
            m_active = 0;
          end
        end
        m_tcu = int'(i_tcu_next);
        if (m_tcu == 15) m_jam = 1'b1;
      end
      m_pend = set_edge || (m_pend && !consume);
    end
    exp_q.push_back(expect_now());
  endtask

  task automatic step();
    @(posedge i_clk);
    model_step();
    #2;
  endtask

  // Behavioural decode ROM: instructions of m_len T-states, 0..m_len-1.
  task automatic drive_rom();
    if (m_tcu == 0) m_len = $urandom_range(2, 6);
    i_tcu_next = (m_tcu >= m_len - 1) ? 4'd0 : 4'(m_tcu + 1);
  endtask

  task automatic run_to_boundary();
    for (int n = 0; n < 20 && m_tcu != 0; n++) begin
      drive_rom();
      i_data = 8'($urandom);
      step();
    end
    tests++;
    if (o_sync !== 1'b1 || m_tcu != 0) begin
      fails++;
      $display("FAIL boundary_reach actual sync=%b required sync=1 (model tcu=%0d)", o_sync, m_tcu);
    end
  endtask

  task automatic boundary_step(input logic [7:0] opcode);
    run_to_boundary();
    i_data = opcode;
    drive_rom();
    step();
  endtask

  initial begin : monitor
    obs_t e_v, a_v;
    forever begin
      @(negedge i_clk);
      if (exp_q.size() > 0) begin
        e_v = exp_q.pop_front();
        a_v = '{o_tcu, o_ir, o_sync, o_int_src, o_vector_lo, o_int_active,
                o_pc_inc_inhibit, o_write_inhibit, o_nmi_pending, o_jam};
        tests++;
        if (a_v !== e_v) begin
          fails++;
          $display("FAIL outputs t=%0t actual tcu=%h ir=%h sync=%b src=%0d vec=%h act=%b pci=%b wi=%b pend=%b jam=%b required tcu=%h ir=%h sync=%b src=%0d vec=%h act=%b pci=%b wi=%b pend=%b jam=%b",
                   $time, a_v.tcu, a_v.ir, a_v.sync, a_v.src, a_v.vec, a_v.active, a_v.pcinh,
                   a_v.wi, a_v.pend, a_v.jam, e_v.tcu, e_v.ir, e_v.sync, e_v.src, e_v.vec,
                   e_v.active, e_v.pcinh, e_v.wi, e_v.pend, e_v.jam);
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    i_reset_n = 1'b0; i_tcu_next = 4'd0; i_data = 8'hEA; i_rw = 1'b1; i_rdy = 1'b1;
    i_nmi_n = 1'b1; i_irq_n = 1'b1; i_i_flag = 1'b1;
    foreach (hist[k]) hist[k] = 1'b1;

    // Reset, then first opcode fetch.
    step(); step();
    i_reset_n = 1'b1;
    boundary_step(8'hA9);

    // IRQ masked, then taken.
    i_irq_n = 1'b0; i_i_flag = 1'b1;
    boundary_step(8'hEA);
    i_i_flag = 1'b0;
    boundary_step(8'hEA);
    i_irq_n = 1'b1;

    // NMI pulse while IRQ held: NMI first, IRQ at the following boundary.
    i_irq_n = 1'b0; i_i_flag = 1'b0;
    i_nmi_n = 1'b0; drive_rom(); step();
    i_nmi_n = 1'b1;
    repeat (4) begin drive_rom(); step(); end
    repeat (3) boundary_step(8'hEA);
    i_irq_n = 1'b1; i_i_flag = 1'b1;

    // Second NMI edge during a running NMI sequence.
    i_nmi_n = 1'b0; drive_rom(); step();
    i_nmi_n = 1'b1;
    for (int n = 0; n < 6 && !(m_src == 2 && m_active); n++) boundary_step(8'hEA);
    m_len = 6;
    drive_rom(); step();
    i_nmi_n = 1'b0; drive_rom(); step();
    i_nmi_n = 1'b1;
    repeat (3) boundary_step(8'hEA);

    // New edge lands on the same edge that consumes the pending flag.
    i_reset_n = 1'b0; step();
    i_reset_n = 1'b1; m_len = 5;
    i_nmi_n = 1'b0; drive_rom(); step();
    i_nmi_n = 1'b1; drive_rom(); step();
    i_nmi_n = 1'b0; drive_rom(); step();
    i_nmi_n = 1'b1;
    repeat (3) boundary_step(8'hEA);

    // RDY stall on a read at T2, then RDY low on writes.
    boundary_step(8'hAD);
    m_len = 6;
    drive_rom(); step();
    i_rw = 1'b1; i_rdy = 1'b0;
    repeat (3) begin drive_rom(); step(); end
    i_rdy = 1'b1; drive_rom(); step();
    i_rw = 1'b0; i_rdy = 1'b0;
    repeat (3) begin drive_rom(); step(); end
    i_rw = 1'b1; i_rdy = 1'b1;

    // Randomised traffic.
    for (int n = 0; n < 1500; n++) begin
      drive_rom();
      i_data    = 8'($urandom);
      i_irq_n   = ($urandom_range(0, 3) != 0);
      i_i_flag  = 1'($urandom_range(0, 1));
      i_nmi_n   = ($urandom_range(0, 9) != 0);
      i_rw      = 1'($urandom_range(0, 1));
      i_rdy     = ($urandom_range(0, 3) != 0);
      i_reset_n = ($urandom_range(0, 199) != 0);
      step();
    end
    i_reset_n = 1'b1; i_rw = 1'b1; i_rdy = 1'b1; i_nmi_n = 1'b1; i_irq_n = 1'b1;

    // Jam: sticky until reset, interrupts and ROM ignored.
    boundary_step(8'h02);
    i_tcu_next = 4'hF; step();
    for (int n = 0; n < 12; n++) begin
      i_tcu_next = 4'($urandom_range(0, 14));
      i_irq_n    = 1'b0; i_i_flag = 1'b0;
      i_nmi_n    = n[1];
      i_data     = 8'($urandom);
      step();
    end
    i_irq_n = 1'b1; i_nmi_n = 1'b1;
    i_reset_n = 1'b0; step();
    i_reset_n = 1'b1;
    boundary_step(8'hA9);
    repeat (4) begin drive_rom(); step(); end

    @(negedge i_clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain actual=%0d left required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu6502_timing_sequencer.md
# cpu6502_timing_sequencer

- Sequential partner to the combinational decode ROM; owns the T-state counter (TCU), the instruction register (IR) and interrupt sequencing for the cpu6502 core.
- Each cycle it registers the ROM's next-TCU value, latches opcodes at instruction boundaries, and injects BRK (0x00) for RESET, NMI and IRQ.
- It reports the interrupt source and vector low byte to the datapath, and handles RDY stalls, write inhibit during reset, and illegal-opcode jam detection.

## Interface
Parameters:
- TCU_WIDTH, 4, width of the T-state counter; the all-ones value is the jam state.
- NMI_SYNC_STAGES, 2, flops in the NMI input synchroniser (minimum 1).

Ports:
- i_clk  in  1  core clock; all state updates on the rising edge.
- i_reset_n  in  1  reset; synchronous, active-low.
- i_tcu_next  in  TCU_WIDTH  next T-state requested by the decode ROM.
- i_data  in  8  data latch contents; the opcode during T0.
- i_rw  in  1  current cycle direction from the decode ROM (1 = read).
- i_rdy  in  1  ready; low stalls read cycles.
- i_nmi_n  in  1  asynchronous NMI request, falling-edge triggered.
- i_irq_n  in  1  IRQ request, level, active-low.
- i_i_flag  in  1  P register I flag.
- o_tcu  out  TCU_WIDTH  current T-state.
- o_ir  out  8  current instruction register.
- o_sync  out  1  high when o_tcu == 0 (opcode fetch cycle).
- o_int_src  out  2  0 = BRK, 1 = IRQ, 2 = NMI, 3 = RESET.
- o_vector_lo  out  8  vector low byte: FE (BRK/IRQ), FA (NMI), FC (RESET).
- o_int_active  out  1  high while an injected (hardware) BRK sequence runs.
- o_pc_inc_inhibit  out  1  suppresses the ROM's PC increment.
- o_write_inhibit  out  1  forces writes to reads (RESET sequence only).
- o_nmi_pending  out  1  latched NMI edge not yet serviced.
- o_jam  out  1  sticky; TCU reached all-ones.

## Operation
Reset values (i_reset_n low at an edge):
- o_tcu = 1, o_ir = 8'h00, o_int_src = 3, o_vector_lo = 8'hFC.
- o_int_active = 1, o_write_inhibit = 1, o_pc_inc_inhibit = 1.
- o_nmi_pending = 0, o_jam = 0, synchroniser flops all 1.
- Reset mid-instruction discards all state, including pending NMI.

Normal operation:
- Each unstalled cycle, tcu <= i_tcu_next.
- Boundary = cycle with o_sync = 1. At the end of that cycle, priority decides the next IR:
  - NMI pending: ir <= 0x00, src = 2, and nmi_pending clears in the same edge.
  - Else IRQ with i_irq_n == 0 and i_i_flag == 0 (both sampled in the boundary cycle): ir <= 0x00, src = 1.
  - Else: ir <= i_data. If i_data == 0x00, src = 0 (software BRK).
- For src 1/2/3, o_int_active and o_pc_inc_inhibit are set from the injected boundary until the next o_sync cycle.
- o_write_inhibit is high only while src == 3 and o_int_active.
- The vector follows the source; BRK and IRQ share FE.

NMI:
- Falling edge of the synchronised i_nmi_n sets nmi_pending.
- An edge arriving during a running NMI sequence stays latched for the next boundary.
- An edge in the same cycle the pending flag is consumed stays set (set wins).
- IRQ is not latched; if released before the boundary, it is not taken.

RDY and jam:
- Stall when i_rdy == 0 and i_rw == 1: tcu, ir, src and flags hold. The NMI synchroniser and edge latch keep running.
- i_rdy is ignored on write cycles.
- If i_tcu_next == all-ones is loaded: o_jam = 1 and the TCU holds at all-ones, ignoring i_tcu_next, until reset.
- Interrupts are not taken while jammed.

## Timing
- All outputs are registered except o_sync, which is a combinational decode of o_tcu.
- NMI latency from the i_nmi_n falling edge to o_nmi_pending is NMI_SYNC_STAGES + 1 cycles. Injection happens at the first boundary after that.
- Opcode to o_ir latency is one edge after the T0 cycle. o_tcu is then the ROM's T1 value.
- A stall extends the cycle by whole clocks, with no partial updates.

## Configuration
- CPU6502_RDY_EN defined: RDY stalling as described.
- Not defined: i_rdy is ignored (treated as 1), the stall logic is removed, and the port remains for pin compatibility.

## Structure
- Package cpu6502_pkg holds:
  - the interrupt-source encodings: INT_SRC_BRK/IRQ/NMI/RESET;
  - vector constants: VEC_LO_NMI = 8'hFA, VEC_LO_RESET = 8'hFC, VEC_LO_IRQ = 8'hFE;
  - OPCODE_BRK = 8'h00;
  - TCU_WIDTH_DEFAULT = 4.
- One sub-module, cpu6502_nmi_edge_detect: parametrised synchroniser plus falling-edge latch with set-priority clear.

## Test plan
- Reset: hold i_reset_n low 2 cycles then release → o_ir = 00, o_tcu = 1, src = 3, vector = FC, write_inhibit = 1. After the ROM returns tcu 0, the next opcode A9 on i_data gives o_ir = A9 and write_inhibit = 0.
- IRQ masking:
  - i_irq_n = 0 with i_i_flag = 1 across a boundary → o_ir = i_data (EA).
  - Repeat with i_i_flag = 0 → o_ir = 00, src = 1, vector = FE, pc_inc_inhibit = 1.
- NMI over IRQ: pulse i_nmi_n low 1 cycle while i_irq_n = 0 → after 3 cycles o_nmi_pending = 1; next boundary gives src = 2, vector = FA, pending cleared. The following boundary takes the IRQ.
- NMI during NMI sequence: a second falling edge mid-sequence → pending stays 1 at the next boundary, giving a second NMI injection.
- RDY (macro defined):
  - i_rdy = 0 on a read cycle at tcu = 2 for 3 clocks → o_tcu stays 2, then advances when i_rdy = 1.
  - i_rdy = 0 with i_rw = 0 → no stall.
- Jam: i_tcu_next = 4'hF → o_jam = 1 and o_tcu stuck at F regardless of input and interrupts. i_reset_n low clears it.
